// File: rtl/adc_calc_pkg.sv
// Shared reset coefficients, serializer state encoding and word-index decode
// for the ADC calibration coefficient bank.
package adc_calc_pkg;

  localparam logic [31:0] GAIN_RST_DEF   = 32'h35A0_0000;
  localparam logic [31:0] OFFSET_RST_DEF = 32'hC120_0000;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } coef_state_e;

  typedef struct packed {
    logic [4:0] ch;
    logic       is_offset;
  } coef_sel_t;

  // Even word = gain, odd word = offset of channel widx/2.
  function automatic coef_sel_t coef_decode(input logic [5:0] widx);
    coef_sel_t sel;
    sel.ch        = widx[5:1];
    sel.is_offset = widx[0];
    return sel;
  endfunction

endpackage

// File: rtl/adc_coef_stream.sv
// AXI-Stream serializer: walks the active bank word by word after each applied
// commit and decides when the parent must copy shadow into active.
module adc_coef_stream
  import adc_calc_pkg::*;
#(
  parameter int unsigned N_CH = 10,
  parameter int unsigned AW   = $clog2(2 * N_CH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_commit,
  input  logic [31:0]   i_word,
  output logic [AW-1:0] o_idx,
  output logic          o_apply,
  output logic          o_busy,
  output logic [31:0]   m_axis_tdata,
  output logic [AW-1:0] m_axis_tuser,
  output logic          m_axis_tvalid,
  output logic          m_axis_tlast,
  input  logic          m_axis_tready
);

  localparam logic [AW-1:0] LAST_IDX = AW'(2 * N_CH - 1);

  coef_state_e   state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          pending_q, pending_d;
  logic          is_last;

  assign is_last = (idx_q == LAST_IDX);
  assign o_idx   = idx_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    pending_d     = pending_q;
    o_apply       = 1'b0;
    o_busy        = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tuser  = '0;
    m_axis_tlast  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_commit) begin
          o_apply   = 1'b1;
          idx_d     = '0;
          pending_d = 1'b0;
          state_d   = ST_STREAM;
        end
      end
      ST_STREAM: begin
        o_busy        = 1'b1;
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = i_word;
        m_axis_tuser  = idx_q;
        m_axis_tlast  = is_last;
        if (i_commit) pending_d = 1'b1;
        if (m_axis_tready) begin
          if (is_last) begin
            // A commit seen at any point in this stream restarts it back-to-back.
            idx_d     = '0;
            pending_d = 1'b0;
            if (pending_q || i_commit) o_apply = 1'b1;
            else                       state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/adc_calc_coef_bank.sv
// Shadow/active gain-offset coefficient banks with commit-driven update and an
// AXI-Stream copy of every applied bank.
module adc_calc_coef_bank
  import adc_calc_pkg::*;
#(
  parameter int unsigned N_CH       = 10,
  parameter logic [31:0] GAIN_RST   = GAIN_RST_DEF,
  parameter logic [31:0] OFFSET_RST = OFFSET_RST_DEF,
  localparam int unsigned AW        = $clog2(2 * N_CH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [31:0]       i_wr_data,
  input  logic              i_commit,
  output logic [N_CH*32-1:0] o_gain,
  output logic [N_CH*32-1:0] o_offset,
  output logic [31:0]       m_axis_tdata,
  output logic [AW-1:0]     m_axis_tuser,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              o_busy,
  output logic              o_dirty
);

  localparam int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned NW = 2 * N_CH;

  logic [31:0]   gain_sh_q  [N_CH];
  logic [31:0]   off_sh_q   [N_CH];
  logic [31:0]   gain_act_q [N_CH];
  logic [31:0]   off_act_q  [N_CH];
  logic          dirty_q;
  logic          wr_ok;
  logic          apply;
  coef_sel_t     wr_sel;
  coef_sel_t     rd_sel;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_word;

  assign wr_ok   = i_wr_en && ({1'b0, i_wr_addr} < (AW + 1)'(NW));
  assign wr_sel  = coef_decode(6'(i_wr_addr));
  assign rd_sel  = coef_decode(6'(rd_idx));
  assign rd_word = rd_sel.is_offset ? off_act_q[rd_sel.ch[CW-1:0]]
                                    : gain_act_q[rd_sel.ch[CW-1:0]];
  assign o_dirty = dirty_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        gain_sh_q[c]  <= GAIN_RST;
        off_sh_q[c]   <= OFFSET_RST;
        gain_act_q[c] <= GAIN_RST;
        off_act_q[c]  <= OFFSET_RST;
      end
      dirty_q <= 1'b0;
    end else begin
      // Commit samples the shadow before a same-cycle write lands, and that
      // write keeps the bank marked dirty.
      if (apply) begin
        gain_act_q <= gain_sh_q;
        off_act_q  <= off_sh_q;
        dirty_q    <= 1'b0;
      end
      if (wr_ok) begin
        if (wr_sel.is_offset) off_sh_q[wr_sel.ch[CW-1:0]]  <= i_wr_data;
        else                  gain_sh_q[wr_sel.ch[CW-1:0]] <= i_wr_data;
        dirty_q <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_pack
    assign o_gain[g*32 +: 32]   = gain_act_q[g];
    assign o_offset[g*32 +: 32] = off_act_q[g];
  end

  adc_coef_stream #(
    .N_CH (N_CH),
    .AW   (AW)
  ) u_stream (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_commit      (i_commit),
    .i_word        (rd_word),
    .o_idx         (rd_idx),
    .o_apply       (apply),
    .o_busy        (o_busy),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
  );

endmodule

// File: doc/adc_calc_coef_bank.md
ADC_CALC_COEF_BANK -- requirements
Module: adc_calc_coef_bank

Interface
REQ-001 SHALL have parameter N_CH, default 10, number of ADC channels (1..32).
REQ-002 SHALL have parameter GAIN_RST, default 32'h35A0_0000, IEEE-754 single gain reset value per channel.
REQ-003 SHALL have parameter OFFSET_RST, default 32'hC120_0000, IEEE-754 single offset reset value (-10.0) per channel.
REQ-004 SHALL have port i_clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_wr_en  input  1  shadow write strobe.
REQ-007 SHALL have port i_wr_addr  input  AW=$clog2(2*N_CH)  word index; even = gain of ch addr/2, odd = offset of ch addr/2.
REQ-008 SHALL have port i_wr_data  input  32  coefficient word.
REQ-009 SHALL have port i_commit  input  1  single-cycle request to copy shadow bank to active bank.
REQ-010 SHALL have port o_gain  output  N_CH*32  active gains, ch0 in bits [31:0].
REQ-011 SHALL have port o_offset  output  N_CH*32  active offsets, same packing.
REQ-012 SHALL have ports m_axis_tdata  output  32, m_axis_tuser  output  AW  (word index), m_axis_tvalid  output  1, m_axis_tlast  output  1, m_axis_tready  input  1: coefficient update stream.
REQ-013 SHALL have port o_busy  output  1  high while state is STREAM.
REQ-014 SHALL have port o_dirty  output  1  shadow written since last applied commit.

Function
REQ-015 Write with i_wr_en=1 and i_wr_addr<2*N_CH SHALL update the shadow word at next edge; i_wr_addr>=2*N_CH SHALL be ignored with no state change.
REQ-016 Active bank SHALL change only on commit application; o_gain/o_offset are registered copies of it, never shadow.
REQ-017 FSM SHALL have states IDLE and STREAM.
REQ-018 IDLE + i_commit: next edge active<=shadow, idx<=0, pending<=0, o_dirty<=0, state->STREAM.
REQ-019 Write and commit in same cycle: commit SHALL copy pre-write shadow; written word lands in shadow, o_dirty stays 1.
REQ-020 STREAM: m_axis_tvalid=1, m_axis_tdata=active word idx, m_axis_tuser=idx, order gain0, offset0, gain1, ... offset(N_CH-1); m_axis_tlast=1 only at idx=2*N_CH-1.
REQ-021 idx SHALL advance only on tvalid&tready; tdata/tuser/tlast SHALL hold stable while tready=0.
REQ-022 i_commit in STREAM SHALL set pending; repeated requests collapse into one; active bank unchanged mid-stream.
REQ-023 Final handshake (tlast&tready) with pending=0: state->IDLE, tvalid 0 next cycle; with pending=1 (or i_commit same cycle): apply commit per REQ-018 and remain STREAM, tvalid stays 1 with idx 0.
REQ-024 m_axis_tdata, m_axis_tuser, m_axis_tlast SHALL be 0 whenever tvalid=0.
REQ-025 Latency: commit in IDLE at edge n -> o_gain/o_offset updated and first beat valid after edge n+1.

Reset
REQ-026 i_rst assertion SHALL immediately (no clock) force shadow and active gains to GAIN_RST, offsets to OFFSET_RST, state IDLE, idx 0, pending 0, o_dirty 0, o_busy 0, m_axis_tvalid 0, m_axis_tlast 0.
REQ-027 Reset mid-stream SHALL abort the stream with no further beats; no commit is retained.
REQ-028 First commit SHALL be accepted at the first rising edge after i_rst deasserts.

Structure
REQ-029 Package adc_calc_pkg SHALL hold GAIN_RST/OFFSET_RST defaults, FSM state enum, and word-index to (channel, type) decode function.
REQ-030 Banks and write/commit logic SHALL sit in top module; AXIS serializer FSM SHALL be one sub-module adc_coef_stream.

Verification
REQ-031 Reset then no writes -> o_gain every ch 32'h35A0_0000, o_offset every ch 32'hC120_0000, tvalid 0.
REQ-032 N_CH=10: write addr 3=32'h3F80_0000, commit, tready=1 -> o_offset[63:32]=3F80_0000 after one edge; 20 beats, beat 3 tdata 3F80_0000, tlast on beat 19, o_busy 0 after.
REQ-033 tready toggling 1/0 each cycle -> 20 beats, tdata/tuser stable during stalls, order preserved.
REQ-034 Commit at beat 5, write addr 0=32'h4000_0000 then second commit at beat 8 -> active unchanged until beat 19 accepted, then one new 20-beat stream, beat 0 tdata 4000_0000.
REQ-035 Write addr 20 (out of range) and same-cycle write+commit on addr 1 -> no change from addr 20; stream carries old addr-1 value, o_dirty=1.
REQ-036 i_rst asserted at beat 7 -> tvalid 0 in same cycle, banks back to defaults, no pending stream after release.
